// File: rtl/xpt_step_sequencer.sv
// Execution-phase step sequencer: drives XPT/notXPT and the latched opcode Source/notSource to the opcode decoders.
// Optional watchdog recovery at MAX_XPT is enabled by defining XPT_SEQ_WATCHDOG_EN.
module xpt_step_sequencer #(
    parameter int FETCH_LEN = 4,
    parameter int MAX_XPT   = 20
) (
    input  logic       clk,
    input  logic       notReset,
    input  logic       step,
    input  logic       wait_req,
    input  logic [7:0] opcode_in,
    input  logic       PR_Reset_XPT,
    input  logic       P2_Set_CM1,
    output logic [4:0] XPT,
    output logic [4:0] notXPT,
    output logic [7:0] Source,
    output logic [7:0] notSource,
    output logic       CM1,
    output logic       decode_enable,
    output logic       seq_err
);

    typedef enum logic {
        FETCH = 1'b0,
        EXEC  = 1'b1
    } state_t;

    localparam logic [4:0] FETCH_LAST = 5'(FETCH_LEN - 1);
    localparam logic [4:0] EXEC_FIRST = 5'(FETCH_LEN);
    localparam logic [4:0] XPT_MAX    = 5'(MAX_XPT);

    state_t     state;
    state_t     state_n;
    logic [4:0] xpt_n;
    logic [7:0] src_n;
    logic       err_n;
    logic       adv;

    assign adv = step & ~wait_req;

    always_comb begin
        xpt_n   = XPT;
        src_n   = Source;
        state_n = state;
        err_n   = seq_err;
        if (adv) begin
            case (state)
                FETCH: begin
                    // Decoder feedback is meaningless until the opcode is latched.
                    if (XPT == FETCH_LAST) begin
                        src_n   = opcode_in;
                        xpt_n   = EXEC_FIRST;
                        state_n = EXEC;
                    end else begin
                        xpt_n = XPT + 5'd1;
                    end
                end
                EXEC: begin
                    if (PR_Reset_XPT) begin
                        xpt_n   = 5'd0;
                        state_n = FETCH;
                        if (!P2_Set_CM1) begin
                            err_n = 1'b1;
                        end
                    end else if (XPT < XPT_MAX) begin
                        xpt_n = XPT + 5'd1;
                    end else begin
`ifdef XPT_SEQ_WATCHDOG_EN
                        // Runaway instruction: flag it and fall back to fetching with a NOP latched.
                        err_n   = 1'b1;
                        xpt_n   = 5'd0;
                        state_n = FETCH;
                        src_n   = 8'h00;
`else
                        xpt_n   = XPT_MAX;
`endif
                    end
                end
                default: begin
                    state_n = FETCH;
                end
            endcase
        end
    end

    // Complements and state decodes are registered from the same next values so they never lag.
    always_ff @(posedge clk or negedge notReset) begin
        if (!notReset) begin
            state         <= FETCH;
            XPT           <= 5'd0;
            notXPT        <= 5'h1F;
            Source        <= 8'h00;
            notSource     <= 8'hFF;
            CM1           <= 1'b1;
            decode_enable <= 1'b0;
            seq_err       <= 1'b0;
        end else begin
            state         <= state_n;
            XPT           <= xpt_n;
            notXPT        <= ~xpt_n;
            Source        <= src_n;
            notSource     <= ~src_n;
            CM1           <= (state_n == FETCH);
            decode_enable <= (state_n == EXEC);
            seq_err       <= err_n;
        end
    end

endmodule

// File: tb/tb_xpt_step_sequencer.sv
// Bench for xpt_step_sequencer: directed scenarios plus randomized traffic against a step-rule reference model.
module tb_xpt_step_sequencer;

    localparam int FETCH_LEN = 4;
    localparam int MAX_XPT   = 20;

    logic       clk = 1'b0;
    logic       notReset;
    logic       step;
    logic       wait_req;
    logic [7:0] opcode_in;
    logic       PR_Reset_XPT;
    logic       P2_Set_CM1;
    logic [4:0] XPT;
    logic [4:0] notXPT;
    logic [7:0] Source;
    logic [7:0] notSource;
    logic       CM1;
    logic       decode_enable;
    logic       seq_err;

    int n_total = 0;
    int n_bad   = 0;

    // reference model state
    int         m_xpt;
    logic [7:0] m_src;
    bit         m_exec;
    bit         m_err;

    xpt_step_sequencer #(.FETCH_LEN(FETCH_LEN), .MAX_XPT(MAX_XPT)) dut (
        .clk(clk), .notReset(notReset), .step(step), .wait_req(wait_req),
        .opcode_in(opcode_in), .PR_Reset_XPT(PR_Reset_XPT), .P2_Set_CM1(P2_Set_CM1),
        .XPT(XPT), .notXPT(notXPT), .Source(Source), .notSource(notSource),
        .CM1(CM1), .decode_enable(decode_enable), .seq_err(seq_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_xpt  = 0;
        m_src  = 8'h00;
        m_exec = 1'b0;
        m_err  = 1'b0;
    endtask

    task automatic model_step();
        if (step && !wait_req) begin
            if (!m_exec) begin
                m_xpt = m_xpt + 1;
                if (m_xpt == FETCH_LEN) begin
                    m_src  = opcode_in;
                    m_exec = 1'b1;
                end
            end else if (PR_Reset_XPT) begin
                m_xpt  = 0;
                m_exec = 1'b0;
                if (!P2_Set_CM1) m_err = 1'b1;
            end else if (m_xpt < MAX_XPT) begin
                m_xpt = m_xpt + 1;
            end else begin
`ifdef XPT_SEQ_WATCHDOG_EN
                m_xpt  = 0;
                m_exec = 1'b0;
                m_src  = 8'h00;
                m_err  = 1'b1;
`endif
            end
        end
    endtask

    task automatic check_all(input string tag);
        logic [4:0] ex;
        ex = m_xpt[4:0];
        chk({tag, ".XPT"},    {27'd0, XPT},       {27'd0, ex});
        chk({tag, ".nXPT"},   {27'd0, notXPT},    {27'd0, ~ex});
        chk({tag, ".Src"},    {24'd0, Source},    {24'd0, m_src});
        chk({tag, ".nSrc"},   {24'd0, notSource}, {24'd0, ~m_src});
        chk({tag, ".CM1"},    {31'd0, CM1},       {31'd0, ~m_exec});
        chk({tag, ".dec_en"}, {31'd0, decode_enable}, {31'd0, m_exec});
        chk({tag, ".err"},    {31'd0, seq_err},   {31'd0, m_err});
    endtask

    // Drive one cycle of inputs, let the edge happen, check at the following negedge.
    task automatic cyc(input string tag, input bit s, input bit w, input logic [7:0] op,
                       input bit pr, input bit p2);
        step = s; wait_req = w; opcode_in = op; PR_Reset_XPT = pr; P2_Set_CM1 = p2;
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all(tag);
    endtask

    // Asynchronous reset pulse between clock edges; outputs must react before any edge.
    task automatic async_reset(input string tag);
        notReset = 1'b0;
        #1;
        model_reset();
        check_all(tag);
        #2;
        notReset = 1'b1;
    endtask

    initial begin
        notReset = 1'b0; step = 1'b0; wait_req = 1'b0; opcode_in = 8'h00;
        PR_Reset_XPT = 1'b0; P2_Set_CM1 = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check_all("rst");
        chk("rst.nXPT_const", {27'd0, notXPT}, 32'h1F);
        notReset = 1'b1;

        // fetch with step held high
        for (int i = 0; i < FETCH_LEN; i++) cyc("fetch", 1, 0, 8'hFF, 0, 0);
        chk("fetch.XPT4", {27'd0, XPT}, 32'd4);
        chk("fetch.CM1lo", {31'd0, CM1}, 32'd0);
        chk("fetch.Src", {24'd0, Source}, 32'hFF);
        chk("fetch.nSrc", {24'd0, notSource}, 32'h00);

        // proper end of instruction at XPT=10
        for (int i = 0; i < 6; i++) cyc("run10", 1, 0, 8'h12, 0, 0);
        chk("run10.XPT", {27'd0, XPT}, 32'd10);
        cyc("endok", 1, 0, 8'h12, 1, 1);
        chk("endok.XPT0", {27'd0, XPT}, 32'd0);
        chk("endok.err0", {31'd0, seq_err}, 32'd0);

        // stall at XPT=6 with a pending reset request held
        for (int i = 0; i < 6; i++) cyc("to6", 1, 0, 8'h3C, 0, 0);
        for (int i = 0; i < 3; i++) cyc("wait", 1, 1, 8'h00, 1, 0);
        chk("wait.XPT6", {27'd0, XPT}, 32'd6);
        cyc("resume", 1, 0, 8'h00, 0, 0);
        chk("resume.XPT7", {27'd0, XPT}, 32'd7);
        cyc("idle", 0, 0, 8'h00, 1, 0);

        // reset request without Set_CM1 at XPT=5
        cyc("end1", 1, 0, 8'h00, 1, 1);
        for (int i = 0; i < 5; i++) cyc("to5", 1, 0, 8'hA5, 0, 0);
        cyc("hs_err", 1, 0, 8'h00, 1, 0);
        chk("hs_err.err1", {31'd0, seq_err}, 32'd1);
        chk("hs_err.CM1", {31'd0, CM1}, 32'd1);
        for (int i = 0; i < 3; i++) cyc("sticky", 1, 0, 8'h00, 0, 0);
        async_reset("clr");

        // run to MAX_XPT with no decoder feedback
        for (int i = 0; i < MAX_XPT; i++) cyc("tomax", 1, 0, 8'h77, 0, 0);
        chk("tomax.XPT", {27'd0, XPT}, MAX_XPT);
        cyc("atmax", 1, 0, 8'h77, 0, 1);
`ifdef XPT_SEQ_WATCHDOG_EN
        chk("wdog.XPT0", {27'd0, XPT}, 32'd0);
        chk("wdog.Src0", {24'd0, Source}, 32'h00);
        chk("wdog.err", {31'd0, seq_err}, 32'd1);
`else
        chk("sat.XPT", {27'd0, XPT}, MAX_XPT);
        chk("sat.err", {31'd0, seq_err}, 32'd0);
`endif
        // reset request and MAX_XPT together: reset wins
        async_reset("rst2");
        for (int i = 0; i < MAX_XPT; i++) cyc("tomax2", 1, 0, 8'h55, 0, 0);
        cyc("maxpr", 1, 0, 8'h55, 1, 1);
        chk("maxpr.XPT0", {27'd0, XPT}, 32'd0);
        chk("maxpr.err0", {31'd0, seq_err}, 32'd0);

        // mid-EXEC async reset at XPT=7, then refetch from 0
        for (int i = 0; i < 7; i++) cyc("to7", 1, 0, 8'hC3, 0, 0);
        chk("to7.XPT", {27'd0, XPT}, 32'd7);
        async_reset("midrst");
        cyc("refetch", 1, 0, 8'h99, 0, 0);
        chk("refetch.XPT1", {27'd0, XPT}, 32'd1);

        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            bit s, w, pr, p2;
            s  = ($urandom % 4) != 0;
            w  = ($urandom % 6) == 0;
            pr = (((i / 150) % 3) != 2) && (($urandom % 10) == 0);
            p2 = pr ? (($urandom % 5) != 0) : ($urandom % 2 == 1);
            cyc("rnd", s, w, 8'($urandom), pr, p2);
            if (($urandom % 400) == 0) async_reset("rndrst");
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
